// File: rtl/j_timer_pkg.sv
// j_timer_pkg: shared width, counter word type and reset constant for the Jerry timer.
package j_timer_pkg;
  localparam int J_TIMER_W = 16;
  typedef logic [J_TIMER_W-1:0] cnt_t;
  localparam cnt_t CNT_RST = '0;
endpackage

// File: rtl/j_timer_dcnt.sv
// j_timer_dcnt: loadable down-counter with reload register; reloads at zero, terminal count while enabled at zero.
module j_timer_dcnt
  import j_timer_pkg::*;
#(
  parameter int W = J_TIMER_W
) (
  input  logic         sys_clk,
  input  logic         resl,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         tc
);
  logic [W-1:0] rel;
  always_ff @(posedge sys_clk or negedge resl)
    if (!resl) begin
      rel <= W'(CNT_RST);
      q   <= W'(CNT_RST);
    end else if (ld) begin
      rel <= din;
      q   <= din;
    end else if (en) begin
      q <= (q == '0) ? rel : q - W'(1);
    end
  assign tc = en & (q == '0);
endmodule

// File: rtl/j_timer.sv
// j_timer: prescaler feeding a divider; interrupt every (P+1)*(D+1) cycles, stopped while the divider reload is 0.
// Optional macro J_TIMER_IRQ_LATCH_EN makes tint sticky until irq_ack.
module j_timer
  import j_timer_pkg::*;
#(
  parameter int WIDTH = J_TIMER_W
) (
  input  logic             sys_clk,
  input  logic             resl,
  input  logic             pre_wr,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pre_q,
  output logic [WIDTH-1:0] div_q,
  output logic             tick,
  output logic             tint
`ifdef J_TIMER_IRQ_LATCH_EN
  ,
  input  logic             irq_ack
`endif
);
  logic run, div_tc, evt;
  // Shadow of (divider reload != 0), tracked at write time so the counter stays generic.
  always_ff @(posedge sys_clk or negedge resl)
    if (!resl) run <= 1'b0;
    else if (div_wr) run <= (din != '0);
  j_timer_dcnt #(.W(WIDTH)) u_pre (
    .sys_clk(sys_clk), .resl(resl), .en(run), .ld(pre_wr), .din(din), .q(pre_q), .tc(tick)
  );
  j_timer_dcnt #(.W(WIDTH)) u_div (
    .sys_clk(sys_clk), .resl(resl), .en(tick), .ld(div_wr), .din(din), .q(div_q), .tc(div_tc)
  );
  assign evt = div_tc & ~div_wr;
  always_ff @(posedge sys_clk or negedge resl)
    if (!resl) tint <= 1'b0;
`ifdef J_TIMER_IRQ_LATCH_EN
    else tint <= evt | (tint & ~irq_ack);
`else
    else tint <= evt;
`endif
endmodule

// File: tb/tb_j_timer.sv
// tb_j_timer: directed self-checking bench for j_timer (period, divide-by-1, stop, collision, async reset, latch build).
module tb_j_timer;
  logic        sys_clk = 1'b0;
  logic        resl = 1'b0;
  logic        pre_wr = 1'b0;
  logic        div_wr = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] pre_q, div_q;
  logic        tick, tint;
  int          vec = 0;
  int          err = 0;
`ifdef J_TIMER_IRQ_LATCH_EN
  logic        irq_ack = 1'b0;
`endif

  j_timer dut (
    .sys_clk(sys_clk), .resl(resl), .pre_wr(pre_wr), .div_wr(div_wr), .din(din),
    .pre_q(pre_q), .div_q(div_q), .tick(tick), .tint(tint)
`ifdef J_TIMER_IRQ_LATCH_EN
    , .irq_ack(irq_ack)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic clk1();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    pre_wr = 1'b0;
    div_wr = 1'b0;
    din = '0;
    resl = 1'b0;
    clk1();
    resl = 1'b1;
  endtask

  task automatic wr_pre(input logic [15:0] v);
    pre_wr = 1'b1;
    din = v;
    clk1();
    pre_wr = 1'b0;
  endtask

  task automatic wr_div(input logic [15:0] v);
    div_wr = 1'b1;
    din = v;
    clk1();
    div_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if ({pre_q, div_q, tick, tint} !== 34'd0) begin
      err++;
      $display("FAIL reset: pre_q=%0d div_q=%0d tick=%b tint=%b, required all 0", pre_q, div_q, tick, tint);
    end
  endtask

  task automatic test_period();
    logic [15:0] ep, ed;
    do_reset();
    wr_pre(16'd2);
    vec++;
    if (pre_q !== 16'd2 || div_q !== 16'd0 || tick !== 1'b0) begin
      err++;
      $display("FAIL period_stopped: pre_q=%0d div_q=%0d tick=%b, required 2 0 0", pre_q, div_q, tick);
    end
    wr_div(16'd3);
    for (int k = 0; k <= 24; k++) begin
      ep = 16'(2 - (k % 3));
      ed = 16'(3 - ((k / 3) % 4));
      vec++;
      if (pre_q !== ep || div_q !== ed || tick !== (ep == 16'd0) || tint !== (k > 0 && k % 12 == 0)) begin
        err++;
        $display("FAIL period k=%0d: pre_q=%0d div_q=%0d tick=%b tint=%b, required %0d %0d %b %b",
                 k, pre_q, div_q, tick, tint, ep, ed, ep == 16'd0, k > 0 && k % 12 == 0);
      end
      clk1();
    end
  endtask

  task automatic test_div1();
    do_reset();
    wr_pre(16'd0);
    wr_div(16'd1);
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (tick !== 1'b1 || tint !== (k >= 2 && k % 2 == 0)) begin
        err++;
        $display("FAIL div1 k=%0d: tick=%b tint=%b, required 1 %b", k, tick, tint, k >= 2 && k % 2 == 0);
      end
      clk1();
    end
  endtask

  task automatic test_stop();
    do_reset();
    wr_pre(16'd1);
    wr_div(16'd4);
    repeat (5) clk1();
    vec++;
    if (pre_q !== 16'd0 || div_q !== 16'd2) begin
      err++;
      $display("FAIL stop_pre: pre_q=%0d div_q=%0d, required 0 2", pre_q, div_q);
    end
    wr_div(16'd0);
    for (int k = 0; k < 20; k++) begin
      vec++;
      if (pre_q !== 16'd1 || div_q !== 16'd0 || tick !== 1'b0 || tint !== 1'b0) begin
        err++;
        $display("FAIL stop k=%0d: pre_q=%0d div_q=%0d tick=%b tint=%b, required 1 0 0 0", k, pre_q, div_q, tick, tint);
      end
      clk1();
    end
  endtask

  task automatic test_collision();
    do_reset();
    wr_pre(16'd0);
    wr_div(16'd1);
    clk1();
    vec++;
    if (div_q !== 16'd0 || tick !== 1'b1) begin
      err++;
      $display("FAIL collision_pre: div_q=%0d tick=%b, required 0 1", div_q, tick);
    end
    wr_div(16'd5);
    vec++;
    if (div_q !== 16'd5 || tint !== 1'b0) begin
      err++;
      $display("FAIL collision: div_q=%0d tint=%b, required 5 0", div_q, tint);
    end
    for (int k = 1; k <= 6; k++) begin
      clk1();
      vec++;
      if (tint !== (k == 6) || div_q !== ((k == 6) ? 16'd5 : 16'(5 - k))) begin
        err++;
        $display("FAIL collision_after k=%0d: div_q=%0d tint=%b, required %0d %b",
                 k, div_q, tint, (k == 6) ? 5 : 5 - k, k == 6);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr_pre(16'd3);
    wr_div(16'd2);
    repeat (5) clk1();
    vec++;
    if (pre_q !== 16'd2 || div_q !== 16'd1) begin
      err++;
      $display("FAIL areset_pre: pre_q=%0d div_q=%0d, required 2 1", pre_q, div_q);
    end
    #2;
    resl = 1'b0;
    #1;
    vec++;
    if ({pre_q, div_q, tick, tint} !== 34'd0) begin
      err++;
      $display("FAIL areset: pre_q=%0d div_q=%0d tick=%b tint=%b, required all 0", pre_q, div_q, tick, tint);
    end
    clk1();
    resl = 1'b1;
    for (int k = 0; k < 20; k++) begin
      clk1();
      vec++;
      if ({pre_q, div_q, tick, tint} !== 34'd0) begin
        err++;
        $display("FAIL areset_after k=%0d: pre_q=%0d div_q=%0d tick=%b tint=%b, required all 0", k, pre_q, div_q, tick, tint);
      end
    end
  endtask

`ifdef J_TIMER_IRQ_LATCH_EN
  task automatic test_latch();
    logic exp [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    wr_pre(16'd0);
    wr_div(16'd1);
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (tint !== exp[k]) begin
        err++;
        $display("FAIL latch k=%0d: tint=%b, required %b", k, tint, exp[k]);
      end
      irq_ack = (k == 4 || k == 5);
      clk1();
    end
    irq_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_period();
    test_div1();
    test_stop();
    test_collision();
    test_async_reset();
`ifdef J_TIMER_IRQ_LATCH_EN
    test_latch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
